// File: rtl/serial_shiftin_receiver_pkg.sv
// Shared word width, receiver state encoding and counter-width helper
// for the MSB-first serial receiver and its holding register.
package serial_shiftin_receiver_pkg;

    localparam int WIDTH = 32;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    function automatic int clog2_cnt(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/serial_shiftin_receiver_rx_hold_reg.sv
// One-entry valid/ready holding register with a sticky overrun flag.
// Latency: load to valid in 1 cycle. A load while full and not drained is dropped.
module serial_shiftin_receiver_rx_hold_reg #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            load_i,
    input  logic [SIZE-1:0] word_i,
    input  logic            ready_i,
    output logic [SIZE-1:0] data_o,
    output logic            valid_o,
    output logic            overrun_o
);

    logic [SIZE-1:0] data_q;
    logic            valid_q;
    logic            overrun_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (load_i) begin
            // A word draining this same cycle frees the slot for the new one.
            if (valid_q && !ready_i) begin
                overrun_q <= 1'b1;
            end else begin
                data_q  <= word_i;
                valid_q <= 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_shiftin_receiver.sv
// MSB-first serial-to-parallel receiver feeding a one-entry valid/ready output register.
// Word valid 1 cycle after its last bit; completions while the output is stalled set oOverrun.
module serial_shiftin_receiver
    import serial_shiftin_receiver_pkg::*;
#(
    parameter int SIZE  = WIDTH,
    parameter int CNT_W = clog2_cnt(SIZE)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iFrameStart,
    input  logic             iSerialValid,
    input  logic             iSerialBit,
    input  logic             iDataReady,
    output logic [SIZE-1:0]  oData,
    output logic             oDataValid,
    output logic             oBusy,
    output logic             oOverrun,
    output logic [CNT_W-1:0] oBitCount
);

    rx_state_t        state_q, state_d;
    logic [SIZE-1:0]  shreg_q, shreg_d, shreg_base;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic [SIZE-1:0]  word;
    logic             load;

    always_comb begin
        shreg_base = iFrameStart ? '0 : shreg_q;
        cnt_base   = iFrameStart ? '0 : cnt_q;
        word       = {shreg_base[SIZE-2:0], iSerialBit};
        shreg_d    = shreg_base;
        cnt_d      = cnt_base;
        load       = 1'b0;
        if (iSerialValid) begin
            if (cnt_base == CNT_W'(SIZE - 1)) begin
                load    = 1'b1;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = word;
                cnt_d   = cnt_base + 1'b1;
            end
        end
        state_d = (cnt_d == '0) ? RX_IDLE : RX_SHIFT;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= RX_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_shiftin_receiver_rx_hold_reg #(
        .SIZE (SIZE)
    ) u_hold (
        .clk_i     (Clock),
        .rst_n_i   (Reset),
        .load_i    (load),
        .word_i    (word),
        .ready_i   (iDataReady),
        .data_o    (oData),
        .valid_o   (oDataValid),
        .overrun_o (oOverrun)
    );

    assign oBusy     = (state_q == RX_SHIFT);
    assign oBitCount = cnt_q;

endmodule

// File: tb/tb_serial_shiftin_receiver.sv
// Bench for serial_shiftin_receiver: directed scenarios plus random traffic
// checked every cycle against a bit-queue reference model.
module tb_serial_shiftin_receiver;
    import serial_shiftin_receiver_pkg::*;

    localparam int SIZE  = WIDTH;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic             clk;
    logic             rst_n;
    logic             fs, sv, sbit, rdy;
    logic [SIZE-1:0]  o_data;
    logic             o_vld, o_busy, o_ovr;
    logic [CNT_W-1:0] o_cnt;

    serial_shiftin_receiver #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .Clock        (clk),
        .Reset        (rst_n),
        .iFrameStart  (fs),
        .iSerialValid (sv),
        .iSerialBit   (sbit),
        .iDataReady   (rdy),
        .oData        (o_data),
        .oDataValid   (o_vld),
        .oBusy        (o_busy),
        .oOverrun     (o_ovr),
        .oBitCount    (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits of the partial word in arrival order plus holding register.
    logic            m_bits[$];
    logic [SIZE-1:0] m_data;
    logic            m_vld;
    logic            m_ovr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic            done;
        logic [SIZE-1:0] w;
        done = 1'b0;
        w    = '0;
        if (!rst_n) begin
            m_bits.delete();
            m_data = '0;
            m_vld  = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (fs) m_bits.delete();
            if (sv) begin
                m_bits.push_back(sbit);
                if (m_bits.size() == SIZE) begin
                    done = 1'b1;
                    for (int i = 0; i < SIZE; i++) w[SIZE-1-i] = m_bits[i];
                    m_bits.delete();
                end
            end
            if (done) begin
                if (m_vld && !rdy) m_ovr = 1'b1;
                else begin
                    m_data = w;
                    m_vld  = 1'b1;
                end
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("data",    64'(o_data), 64'(m_data));
        chk("valid",   64'(o_vld),  64'(m_vld));
        chk("overrun", 64'(o_ovr),  64'(m_ovr));
        chk("count",   64'(o_cnt),  64'(m_bits.size()));
        chk("busy",    64'(o_busy), 64'(m_bits.size() != 0));
    endtask

    task automatic cyc(input logic f, input logic v, input logic b, input logic r, input logic rn);
        fs = f; sv = v; sbit = b; rdy = r; rst_n = rn;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [SIZE-1:0] w, input logic gapped,
                             input logic r_body, input logic r_last);
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (gapped) cyc(1'b0, 1'b0, 1'($urandom), r_body, 1'b1);
            cyc(1'b0, 1'b1, w[i], (i == 0) ? r_last : r_body, 1'b1);
        end
    endtask

    initial begin
        logic [SIZE-1:0] w;
        m_data = '0; m_vld = 1'b0; m_ovr = 1'b0;
        fs = 0; sv = 0; sbit = 0; rdy = 0; rst_n = 0;
        #2;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);

        // Single word, then consume it.
        send_word(32'hA5C3_0F96, 1'b0, 1'b0, 1'b0);
        chk("word1_data", 64'(o_data), 64'hA5C3_0F96);
        cyc(0, 0, 0, 1, 1);

        // Same word with gaps carrying random bits on the line.
        send_word(32'hA5C3_0F96, 1'b1, 1'b0, 1'b0);
        chk("gap_data", 64'(o_data), 64'hA5C3_0F96);
        cyc(0, 0, 0, 1, 1);

        // Overrun: first word stalled, second dropped; then reset.
        send_word(32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("ovr_keep", 64'(o_data), 64'h0000_0001);
        chk("ovr_flag", 64'(o_ovr), 64'h1);
        cyc(0, 0, 0, 0, 0);
        chk("rst_data", 64'(o_data), 64'h0);

        // Back-to-back with consume on the completing cycle.
        send_word(32'h1234_5678, 1'b0, 1'b0, 1'b0);
        send_word(32'h9ABC_DEF0, 1'b0, 1'b0, 1'b1);
        chk("b2b_data", 64'(o_data), 64'h9ABC_DEF0);
        chk("b2b_ovr",  64'(o_ovr),  64'h0);
        cyc(0, 0, 0, 1, 1);

        // Frame restart after 10 bits.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1'($urandom), 1, 1);
        cyc(1, 1, 1, 1, 1);
        for (int i = 0; i < SIZE - 1; i++) cyc(0, 1, 0, 0, 1);
        chk("fs_data", 64'(o_data), 64'h8000_0000);
        cyc(0, 0, 0, 1, 1);

        // Frame start on what would be the last bit.
        for (int i = 0; i < SIZE - 1; i++) cyc(0, 1, 1, 1, 1);
        cyc(1, 1, 1, 1, 1);
        chk("fs_last_cnt", 64'(o_cnt), 64'h1);

        // Reset mid-word and on the completing bit.
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) cyc(0, 1, 1'($urandom), 1, 1);
        cyc(0, 1, 1, 1, 0);
        for (int i = 0; i < SIZE - 1; i++) cyc(0, 1, 1'($urandom), 1, 1);
        cyc(0, 1, 1, 1, 0);
        chk("rst_last_vld", 64'(o_vld), 64'h0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom), ($urandom_range(0, 599) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_shiftin_receiver.md
Name: serial_shiftin_receiver

Overview:
MSB-first serial-to-parallel receiver. It is the receive end of the shift-left serializer link, where each cycle the serializer shifts its word left and drives the MSB out. Incoming bits are accumulated into a SIZE-bit word, and the completed word is handed to a one-entry output holding register with a valid/ready handshake. The block sits between a serial link from another Theia unit and the parallel datapath that consumes words.

Parameters:
SIZE, `WIDTH (32), word width in bits; must be ≥ 2
CNT_W, $clog2(SIZE+1), bit-counter width

Ports:
Clock  in  1  system clock; all state updates on posedge
Reset  in  1  synchronous reset, active-low (0 = reset), sampled on posedge Clock
iFrameStart  in  1  discard any partial word; this cycle's bit, if valid, becomes the word MSB
iSerialValid  in  1  iSerialBit is valid this cycle
iSerialBit  in  1  serial data bit, MSB first
iDataReady  in  1  consumer accepts oData this cycle
oData  out  SIZE  completed word in holding register
oDataValid  out  1  holding register full
oBusy  out  1  partial word in progress (bit count ≠ 0)
oOverrun  out  1  sticky: a completed word was dropped
oBitCount  out  CNT_W  bits collected in current partial word

Behaviour:
- Reset (Reset==0 at posedge):
  - shift register = 0, oData = 0, oDataValid = 0, oOverrun = 0, oBitCount = 0, state = IDLE.
  - Reset has priority over every other input.
- States:
  - IDLE: count 0, oBusy = 0.
  - SHIFT: 0 < count < SIZE, oBusy = 1.
- Shift rule, on iSerialValid:
  - shreg <= {shreg[SIZE-2:0], iSerialBit}, count += 1.
  - The first received bit ends at oData[SIZE-1].
- Transitions:
  - IDLE → SHIFT on iSerialValid.
  - SHIFT → SHIFT on iSerialValid with count+1 < SIZE.
  - SHIFT → IDLE on the SIZE-th valid bit (word complete).
  - If iSerialValid==0, hold state, count and shreg.
- Word completion:
  - On the posedge that samples the SIZE-th bit, the assembled word {shreg[SIZE-2:0], bit} is loaded into oData.
  - oDataValid = 1 from the next cycle; latency from last bit to valid = 1 cycle.
  - Count returns to 0 in the same edge.
- Handshake:
  - The word transfers on a cycle with oDataValid && iDataReady; oDataValid clears at the next edge unless a new word completes in that same cycle.
  - oData holds stable while oDataValid && !iDataReady.
  - When oDataValid==0, oData keeps its last value (don't-care for consumers).
- Simultaneous completion and consume (oDataValid && iDataReady, with the SIZE-th bit): the new word loads and oDataValid stays 1. No overrun.
- Overrun (completion while oDataValid && !iDataReady):
  - The new word is dropped; oData keeps the old word.
  - oOverrun <= 1 and stays 1 until reset.
  - The counter still returns to 0.
- iFrameStart:
  - Count and shreg are cleared before the shift.
  - With iSerialValid the count becomes 1 and state SHIFT; without it, IDLE.
  - Does not affect the holding register or oOverrun.
  - iFrameStart in the same cycle as what would be the SIZE-th bit: the partial word is discarded, no completion, and the bit starts a new word.
- SIZE==2 corner: the word completes on the second valid bit; the IDLE/SHIFT logic must hold for it.
- Arithmetic: count is unsigned CNT_W and never exceeds SIZE; no wrap-around state is reachable.

Decomposition:
- Shared package/defines: `WIDTH, state encodings RX_IDLE / RX_SHIFT, and a CLOG2 helper macro.
- One natural sub-module, rx_hold_reg: the one-entry valid/ready holding register with the overrun flag. It takes load/word/ready and gives data/valid/overrun.
- The shift register and counter live in the top level.

Test Plan:
- Reset released, feed 32 valid bits of 0xA5C3_0F96 MSB-first → oDataValid rises exactly 1 cycle after the 32nd bit with oData==0xA5C30F96; oBusy==1 during bits 1–31; oBitCount counts 1..31 then 0.
- Same word with iSerialValid gapped every other cycle → identical oData, with no spurious shifts during gaps.
- Word 1 = 0x0000_0001 held (iDataReady=0), then word 2 = 0xFFFF_FFFF completes → oData stays 0x00000001 and oOverrun latches 1; after Reset low for one cycle, all outputs are 0.
- Back-to-back words 0x1234_5678 then 0x9ABC_DEF0, with iDataReady=1 on the completion cycle of word 2 → oDataValid stays 1, oData==0x9ABCDEF0, oOverrun==0.
- After 10 bits, pulse iFrameStart with iSerialValid and bit=1, then 31 more bits of 0x00000000's tail → oData==0x80000000; the first 10 bits are discarded.
- Assert Reset (low) mid-word after 17 bits and in the same cycle as the SIZE-th bit → no completion; count, oBusy and oDataValid are 0 on the next cycle.
